// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the PC sequencer: state encoding,
// opcode values and the opcode field width.
package pc_sequencer_pkg;

  // Opcode occupies the top nibble of the instruction word.
  localparam int OPCODE_W = 4;

  // Flow-control opcodes; every other value is an ALU/NOP instruction.
  localparam logic [OPCODE_W-1:0] OP_BRA   = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_WAITH = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_WAITL = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

  // Sequencer states. FETCH covers the one-cycle ROM latency.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
// A change on d_in appears on q_out two clock edges later.
module pc_sequencer_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-value logic for the two synchroniser stages.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchroniser stages, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-flow controller. Decodes the ROM word in a FETCH/EXEC
// sequence and issues exactly one programCounter update per executed
// instruction (except HALT). Supports conditional branches on the ALU
// zero flag, wait-for-handshake, stall and a sticky halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int P_SIZE = 6,
  parameter int I_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [I_SIZE-1:0] instrIn,
  input  logic              zeroFlagIn,
  input  logic              handshakeIn,
  input  logic              stallIn,
  output logic              inc,
  output logic              branchAbs,
  output logic              branchRel,
  output logic [P_SIZE-1:0] branchAddressOut,
  output logic              exEnable,
  output logic              halted
);

  state_e              state_q, state_d;
  logic                wait_level_q, wait_level_d;
  logic                hs_sync;
  logic [OPCODE_W-1:0] opcode;

  // Bits between the opcode and the target field carry no meaning here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instrIn[I_SIZE-OPCODE_W-1:P_SIZE];

  assign opcode           = instrIn[I_SIZE-1 -: OPCODE_W];
  // The PC does any branch arithmetic; the sequencer only forwards the field.
  assign branchAddressOut = instrIn[P_SIZE-1:0];
  assign halted           = (state_q == ST_HALT);

  // The external handshake is asynchronous and must be synchronised.
  pc_sequencer_sync2 u_hs_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (handshakeIn),
    .q_out (hs_sync)
  );

  // Next-state and pulse decode; a stall holds state and suppresses pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    wait_level_d = wait_level_q;
    inc          = 1'b0;
    branchAbs    = 1'b0;
    branchRel    = 1'b0;
    exEnable     = 1'b0;

    if (!stallIn) begin
      unique case (state_q)
        ST_FETCH: begin
          state_d = ST_EXEC;
        end

        ST_EXEC: begin
          state_d = ST_FETCH;
          case (opcode)
            OP_BRA: begin
              branchAbs = 1'b1;
            end
            OP_BEQ: begin
              if (zeroFlagIn) branchRel = 1'b1;
              else            inc       = 1'b1;
            end
            OP_BNE: begin
              if (!zeroFlagIn) branchRel = 1'b1;
              else             inc       = 1'b1;
            end
            OP_WAITH, OP_WAITL: begin
              wait_level_d = (opcode == OP_WAITH);
              state_d      = ST_WAIT;
            end
            OP_HALT: begin
              state_d = ST_HALT;
            end
            default: begin
              exEnable = 1'b1;
              inc      = 1'b1;
            end
          endcase
        end

        ST_WAIT: begin
          // Release in the first cycle the synchronised level matches.
          if (hs_sync == wait_level_q) begin
            inc     = 1'b1;
            state_d = ST_FETCH;
          end
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  // Sequencer state and the latched wait polarity.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (rst) begin
      state_q      <= ST_FETCH;
      wait_level_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_level_q <= wait_level_d;
    end
  end

endmodule
